// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : counter command encodings and FSM state type shared by UART RX/TX
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam logic [1:0] CNT_HOLD = 2'b00;
  localparam logic [1:0] CNT_INC  = 2'b01;
  localparam logic [1:0] CNT_CLR  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_2ff.sv
`default_nettype none
// ============================================================================
// uart_sync_2ff : two-flop synchroniser for an asynchronous single-bit input
// Revision      : 1.0
// ============================================================================
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule : uart_sync_2ff
`default_nettype wire

// File: rtl/uart_rx_controller.sv
`default_nettype none
// ============================================================================
// uart_rx_controller : UART receive FSM driving an external baud/bit/shift datapath
// Revision           : 1.0
// ============================================================================
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int START_FILTER = 468
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_line,
  input  logic                 Baud_Count_Reached,
  input  logic                 Bit_Count_Reached,
  input  logic [WORD_SIZE-1:0] RX_Data_out,
  output logic [1:0]           Baud_Counter_sel,
  output logic [1:0]           Bit_Counter_sel,
  output logic                 RX_Shift_Register_sel,
  output logic                 RX_Data_in,
  output logic [WORD_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int                FILT_W    = $clog2(START_FILTER + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(START_FILTER - 1);

  logic                 w_rx_s;
  uart_state_e          r_state;
  uart_state_e          w_next_state;
  logic [FILT_W-1:0]    r_filt_cnt;
  logic                 w_filt_clr;
  logic                 w_filt_inc;
  logic                 w_present;
  logic                 w_frame_err;
  logic [1:0]           w_baud_sel;
  logic [1:0]           w_bit_sel;
  logic                 w_shift;
  logic [WORD_SIZE-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_framing_err;
  logic                 r_overrun_err;

  uart_sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_line),
    .q     (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_baud_sel   = CNT_HOLD;
    w_bit_sel    = CNT_HOLD;
    w_shift      = 1'b0;
    w_filt_clr   = 1'b0;
    w_filt_inc   = 1'b0;
    w_present    = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_baud_sel = CNT_CLR;
        w_bit_sel  = CNT_CLR;
        if (!w_rx_s) begin
          w_next_state = ST_START;
          w_filt_clr   = 1'b1;
        end
      end
      ST_START: begin
        // Baud counter stays cleared so the first data sample lands mid-bit.
        w_baud_sel = CNT_CLR;
        w_bit_sel  = CNT_CLR;
        if (w_rx_s) begin
          w_next_state = ST_IDLE;
        end else if (r_filt_cnt == FILT_LAST) begin
          w_next_state = ST_DATA;
        end else begin
          w_filt_inc = 1'b1;
        end
      end
      ST_DATA: begin
        w_baud_sel = CNT_INC;
        if (Bit_Count_Reached) begin
          w_bit_sel    = CNT_CLR;
          w_next_state = ST_STOP;
        end else if (Baud_Count_Reached) begin
          w_shift   = 1'b1;
          w_bit_sel = CNT_INC;
        end
      end
      ST_STOP: begin
        w_baud_sel = CNT_INC;
        if (Baud_Count_Reached) begin
          if (w_rx_s) begin
            w_present    = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_next_state = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        w_baud_sel = CNT_CLR;
        w_bit_sel  = CNT_CLR;
        if (w_rx_s) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt_cnt <= '0;
    end else if (w_filt_clr) begin
      r_filt_cnt <= '0;
    end else if (w_filt_inc) begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  // A handshake in the same cycle as a new byte frees the slot, so no overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_framing_err <= w_frame_err;
      r_overrun_err <= 1'b0;
      if (w_present) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= RX_Data_out;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun_err <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign Baud_Counter_sel      = w_baud_sel;
  assign Bit_Counter_sel       = w_bit_sel;
  assign RX_Shift_Register_sel = w_shift;
  assign RX_Data_in            = w_rx_s;
  assign rx_data               = r_rx_data;
  assign rx_valid              = r_rx_valid;
  assign framing_err           = r_framing_err;
  assign overrun_err           = r_overrun_err;
  assign busy                  = (r_state != ST_IDLE);

endmodule : uart_rx_controller
`default_nettype wire

// File: tb/tb_uart_rx_controller.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_controller : directed bench with behavioural baud/bit/shift datapath
// Revision              : 1.0
// ============================================================================
module tb_uart_rx_controller;

  localparam int W   = 8;
  localparam int BIT = 937;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx_line;
  logic         rx_ready;
  logic         baud_reached;
  logic         bit_reached;
  logic [W-1:0] sh_reg;
  logic [1:0]   baud_sel;
  logic [1:0]   bit_sel;
  logic         shift_sel;
  logic         rx_din;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         framing_err;
  logic         overrun_err;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int n_load  = 0;
  int n_shift = 0;
  int n_fe    = 0;
  int n_ov    = 0;
  int n_drop  = 0;
  logic         p_valid = 1'b0;
  logic         p_ready = 1'b0;
  logic [W-1:0] p_data  = '0;
  logic [9:0]   baud_cnt;
  logic [3:0]   bit_cnt;

  always #5 clk = ~clk;

  uart_rx_controller #(
    .WORD_SIZE    (W),
    .START_FILTER (468)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .rx_line               (rx_line),
    .Baud_Count_Reached    (baud_reached),
    .Bit_Count_Reached     (bit_reached),
    .RX_Data_out           (sh_reg),
    .Baud_Counter_sel      (baud_sel),
    .Bit_Counter_sel       (bit_sel),
    .RX_Shift_Register_sel (shift_sel),
    .RX_Data_in            (rx_din),
    .rx_data               (rx_data),
    .rx_valid              (rx_valid),
    .rx_ready              (rx_ready),
    .framing_err           (framing_err),
    .overrun_err           (overrun_err),
    .busy                  (busy)
  );

  // Existing RX datapath: 937-count baud counter, bit counter, LSB-first shifter
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sh_reg   <= '0;
    end else begin
      case (baud_sel)
        2'b10:   baud_cnt <= '0;
        2'b01:   baud_cnt <= (baud_cnt == 10'(BIT - 1)) ? 10'd0 : baud_cnt + 10'd1;
        default: baud_cnt <= baud_cnt;
      endcase
      case (bit_sel)
        2'b10:   bit_cnt <= '0;
        2'b01:   bit_cnt <= bit_cnt + 4'd1;
        default: bit_cnt <= bit_cnt;
      endcase
      if (shift_sel) sh_reg <= {rx_din, sh_reg[W-1:1]};
    end
  end

  assign baud_reached = (baud_cnt == 10'(BIT - 1));
  assign bit_reached  = (bit_cnt == 4'(W));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_line = v;
    tick(BIT);
  endtask

  task automatic send_data(input logic [W-1:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < W; i++) drive_bit(b[i]);
  endtask

  task automatic send_frame(input logic [W-1:0] b);
    send_data(b);
    drive_bit(1'b1);
  endtask

  // Output monitor: a byte is loaded when rx_valid rises or survives a handshake
  always @(negedge clk) begin
    if (shift_sel === 1'b1)   n_shift++;
    if (framing_err === 1'b1) n_fe++;
    if (overrun_err === 1'b1) n_ov++;
    if (p_valid && rx_valid !== 1'b1) n_drop++;
    if (rx_valid === 1'b1) begin
      if (!p_valid || p_ready) begin
        n_load++;
        chk("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end else begin
        chk("rx_data_stable", 32'(rx_data), 32'(p_data));
      end
    end
    p_valid = (rx_valid === 1'b1);
    p_ready = rx_ready;
    p_data  = rx_data;
  end

  initial begin
    int  s0, l0, f0, o0, d0;
    bit  found;

    reset    = 1'b1;
    rx_line  = 1'b1;
    rx_ready = 1'b0;
    tick(3);
    chk("rst_rx_valid",  32'(rx_valid),    32'd0);
    chk("rst_rx_data",   32'(rx_data),     32'd0);
    chk("rst_framing",   32'(framing_err), 32'd0);
    chk("rst_overrun",   32'(overrun_err), 32'd0);
    chk("rst_busy",      32'(busy),        32'd0);
    chk("rst_baud_sel",  32'(baud_sel),    32'd2);
    chk("rst_bit_sel",   32'(bit_sel),     32'd2);
    chk("rst_shift_sel", 32'(shift_sel),   32'd0);
    chk("rst_sync",      32'(rx_din),      32'd1);
    reset = 1'b0;
    tick(10);

    // Clean 0xA5 with consumer always ready
    rx_ready = 1'b1;
    s0 = n_shift; l0 = n_load; f0 = n_fe; o0 = n_ov;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5);
    tick(20);
    chk("a5_loads",   32'(n_load - l0),  32'd1);
    chk("a5_shifts",  32'(n_shift - s0), 32'd8);
    chk("a5_fe",      32'(n_fe - f0),    32'd0);
    chk("a5_ov",      32'(n_ov - o0),    32'd0);
    chk("a5_valid",   32'(rx_valid),     32'd0);
    chk("a5_busy",    32'(busy),         32'd0);

    // 200-clock glitch must be rejected
    s0 = n_shift; l0 = n_load; f0 = n_fe;
    rx_line = 1'b0;
    tick(100);
    chk("glitch_busy_mid", 32'(busy), 32'd1);
    tick(100);
    rx_line = 1'b1;
    tick(20);
    chk("glitch_busy_end", 32'(busy),         32'd0);
    chk("glitch_shifts",   32'(n_shift - s0), 32'd0);
    chk("glitch_loads",    32'(n_load - l0),  32'd0);
    chk("glitch_fe",       32'(n_fe - f0),    32'd0);

    // 0x3C with stop bit held low
    s0 = n_shift; l0 = n_load; f0 = n_fe;
    send_data(8'h3C);
    rx_line = 1'b0;
    tick(BIT + 1000);
    chk("fe_pulses",   32'(n_fe - f0),    32'd1);
    chk("fe_loads",    32'(n_load - l0),  32'd0);
    chk("fe_valid",    32'(rx_valid),     32'd0);
    chk("fe_shifts",   32'(n_shift - s0), 32'd8);
    chk("fe_busy_low", 32'(busy),         32'd1);
    rx_line = 1'b1;
    tick(10);
    chk("fe_busy_high", 32'(busy), 32'd0);

    // Two bytes with no consumer: second one overruns
    rx_ready = 1'b0;
    l0 = n_load; o0 = n_ov;
    exp_q.push_back(8'h11);
    send_frame(8'h11);
    send_frame(8'h22);
    tick(5);
    chk("ovr_pulses", 32'(n_ov - o0),   32'd1);
    chk("ovr_loads",  32'(n_load - l0), 32'd1);
    chk("ovr_data",   32'(rx_data),     32'h11);
    chk("ovr_valid",  32'(rx_valid),    32'd1);
    rx_ready = 1'b1;
    tick(2);
    chk("ovr_drained", 32'(rx_valid), 32'd0);

    // Reset at bit 4 of 0xFF, then a clean 0x5A
    l0 = n_load; f0 = n_fe; o0 = n_ov;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    tick(2);
    chk("mid_rst_busy",  32'(busy),     32'd0);
    chk("mid_rst_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_data",  32'(rx_data),  32'd0);
    tick(1);
    reset = 1'b0;
    tick(200);
    chk("mid_idle", 32'(busy), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A);
    tick(5);
    chk("mid_loads", 32'(n_load - l0), 32'd1);
    chk("mid_fe",    32'(n_fe - f0),   32'd0);
    chk("mid_ov",    32'(n_ov - o0),   32'd0);

    // Handshake lands in the same cycle the second byte completes
    rx_ready = 1'b0;
    l0 = n_load; o0 = n_ov;
    exp_q.push_back(8'h81);
    send_frame(8'h81);
    chk("hs_first_valid", 32'(rx_valid), 32'd1);
    d0 = n_drop;
    exp_q.push_back(8'h7E);
    send_data(8'h7E);
    rx_line = 1'b1;
    found = 1'b0;
    for (int i = 0; i < BIT; i++) begin
      if (baud_reached) begin
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        found = 1'b1;
        break;
      end
      tick(1);
    end
    chk("hs_stop_sample_seen", 32'(found), 32'd1);
    tick(600);
    chk("hs_data",   32'(rx_data),     32'h7E);
    chk("hs_valid",  32'(rx_valid),    32'd1);
    chk("hs_drops",  32'(n_drop - d0), 32'd0);
    chk("hs_ov",     32'(n_ov - o0),   32'd0);
    chk("hs_loads",  32'(n_load - l0), 32'd2);
    rx_ready = 1'b1;
    tick(2);
    chk("hs_drained", 32'(rx_valid), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx_controller
`default_nettype wire

// File: doc/uart_rx_controller.md
UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 8, meaning data bits per frame.
REQ-002 The block SHALL have parameter START_FILTER, default 468, meaning the number of consecutive low clocks that confirm a start bit (half of 937-clock bit time).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-004 The block SHALL have these ports:
- rx_line  input  1  raw asynchronous UART line, idle high.
- Baud_Count_Reached  input  1  one-cycle pulse from the baud counter.
- Bit_Count_Reached  input  1  high when the bit counter equals WORD_SIZE.
- RX_Data_out  input  WORD_SIZE  shift-register contents.
- Baud_Counter_sel  output  2  baud counter command.
- Bit_Counter_sel  output  2  bit counter command.
- RX_Shift_Register_sel  output  1  shift enable.
- RX_Data_in  output  1  synchronised line to the shift register.
- rx_data  output  WORD_SIZE  received byte.
- rx_valid  output  1  byte available.
- rx_ready  input  1  consumer accepts byte.
- framing_err  output  1  one-cycle pulse, stop bit low.
- overrun_err  output  1  one-cycle pulse, byte dropped.
- busy  output  1  high in any state except IDLE.

Function
REQ-005 rx_line SHALL pass through a 2-flop synchroniser; all decisions and RX_Data_in SHALL use the synchronised value (rx_s), 2 clocks of latency.
REQ-006 The counter command encoding SHALL be: 2'b00 hold, 2'b01 increment, 2'b10 clear; 2'b11 is never driven.
REQ-007 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK, one-hot or binary.
REQ-008 In IDLE, both counters SHALL be held clear, and a low on rx_s SHALL move the FSM to START, clearing the internal filter counter.
REQ-009 In START, the filter counter SHALL increment while rx_s is low.
- rx_s high before START_FILTER counts: return to IDLE (glitch rejected, no error).
- Reaching START_FILTER: clear the baud counter and enter DATA.
REQ-010 In DATA, the baud counter SHALL increment every cycle.
- On Baud_Count_Reached, the same cycle SHALL assert RX_Shift_Register_sel=1 and Bit_Counter_sel=increment.
- All other cycles SHALL hold shift and bit counter.
REQ-011 When Bit_Count_Reached is seen in DATA, the FSM SHALL clear the bit counter and enter STOP, with the baud counter continuing.
REQ-012 In STOP, the rx_s value on Baud_Count_Reached SHALL select the next action:
- rx_s=1: present the byte and return to IDLE.
- rx_s=0: pulse framing_err, enter BREAK, discard the byte.
REQ-013 In BREAK, the FSM SHALL wait for rx_s high, then enter IDLE.
REQ-014 Byte presentation SHALL depend on rx_valid:
- rx_valid low: rx_data <= RX_Data_out and rx_valid=1 on the next cycle.
- rx_valid high and rx_ready low that cycle: keep the old rx_data and pulse overrun_err.
REQ-015 rx_valid SHALL clear on the cycle after rx_valid&&rx_ready.
REQ-016 If the rx_valid&&rx_ready handshake and a new-byte presentation occur in the same cycle, the new byte SHALL load, rx_valid SHALL stay 1, and no overrun SHALL be flagged.
REQ-017 rx_data SHALL be stable while rx_valid=1.
REQ-018 busy SHALL equal (state != IDLE).

Reset
REQ-019 While reset=1 at a clock edge, the block SHALL enter IDLE and set the outputs to:
- rx_valid=0, rx_data=0, framing_err=0, overrun_err=0, busy=0.
- Both counter sels = clear, shift sel=0, synchroniser flops=1.
REQ-020 Reset asserted mid-frame SHALL abandon the frame with no valid or error pulse, and reception SHALL restart only on a fresh falling edge after reset release.

Structure
REQ-021 The counter command constants (CNT_HOLD, CNT_INC, CNT_CLR) and the FSM state typedef SHALL live in a shared package uart_pkg, also used by the TX controller.
REQ-022 The synchroniser SHALL be the sub-module uart_sync_2ff (clk, reset, d, q, reset value 1).
REQ-023 The block SHALL connect to the existing RX datapath (937-count baud counter, WORD_SIZE bit counter) without modification.

Verification
REQ-024 The bench SHALL include this scenario: frame 0xA5 at 937 clocks/bit, rx_ready=1 -> rx_valid pulses once with rx_data=0xA5, no errors.
REQ-025 The bench SHALL include this scenario: a 200-clock low glitch on an idle line -> FSM returns to IDLE, no shift pulses, no rx_valid.
REQ-026 The bench SHALL include this scenario: frame 0x3C with stop bit held low -> framing_err one pulse, rx_valid stays 0, busy stays high until the line rises.
REQ-027 The bench SHALL include this scenario: frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11 retained, overrun_err one pulse at the second stop.
REQ-028 The bench SHALL include this scenario: reset asserted at bit 4 of frame 0xFF, then a clean 0x5A frame -> only 0x5A is delivered.
REQ-029 The bench SHALL include this scenario: rx_ready asserted in the exact cycle a second byte completes -> new byte loads, rx_valid continuous, no overrun.
